model_matrix_stream_transmitter: RTL and testbench

MODEL_MATRIX_STREAM_TRANSMITTER -- requirements
Module: model_matrix_stream_transmitter

---
 rtl/model_math_pkg.sv | 18 +
 rtl/model_matrix_stream_transmitter_if.sv | 40 ++++
 rtl/model_matrix_stream_buffer.sv | 44 ++++
 rtl/model_matrix_stream_transmitter.sv | 144 ++++++++++++++
 tb/tb_model_matrix_stream_transmitter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/model_math_pkg.sv
// Shared definitions for the matrix streaming models: FSM encodings and the
// control/data constants used by the transmitter and its buffer.
package model_math_pkg;

    typedef enum logic [2:0] {
        ST_STARTER = 3'd0,
        ST_EMIT    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ENDER   = 3'd3
    } state_t;

    localparam logic CTRL_ZERO = 1'b0;
    localparam logic CTRL_ONE  = 1'b1;

    localparam int unsigned DATA_ZERO = 0;
    localparam int unsigned DATA_ONE  = 1;

endpackage

// File: rtl/model_matrix_stream_transmitter_if.sv
// Bus bundle between the matrix transmitter, its loader and its consumer.
interface model_matrix_stream_transmitter_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) ();
    import model_math_pkg::*;

    logic                    WRITE_ENABLE;
    logic [CONTROL_SIZE-1:0] WRITE_I;
    logic [CONTROL_SIZE-1:0] WRITE_J;
    logic [DATA_SIZE-1:0]    WRITE_DATA;
    logic                    START;
    logic [DATA_SIZE-1:0]    SIZE_I_IN;
    logic [DATA_SIZE-1:0]    SIZE_J_IN;
    logic                    NEXT_IN;
    logic                    READY;
    logic                    ERROR;
    logic                    DATA_OUT_I_ENABLE;
    logic                    DATA_OUT_J_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_OUT;
    state_t                  DBG_STATE;

    // Handshake: DATA_OUT_J_ENABLE pulses for one cycle per element (with
    // DATA_OUT_I_ENABLE on the first element of a row); DATA_OUT then holds
    // until NEXT_IN=1 acknowledges it. READY pulses once when the stream ends.
    modport slave (
        input  WRITE_ENABLE, WRITE_I, WRITE_J, WRITE_DATA,
        input  START, SIZE_I_IN, SIZE_J_IN, NEXT_IN,
        output READY, ERROR, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT,
        output DBG_STATE
    );

    modport master (
        output WRITE_ENABLE, WRITE_I, WRITE_J, WRITE_DATA,
        output START, SIZE_I_IN, SIZE_J_IN, NEXT_IN,
        input  READY, ERROR, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT,
        input  DBG_STATE
    );

endinterface

// File: rtl/model_matrix_stream_buffer.sv
// Element store for the matrix transmitter: one write port and one registered
// read port addressed by {row, column}.
module model_matrix_stream_buffer
    import model_math_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [CONTROL_SIZE-1:0] wr_i_i,
    input  logic [CONTROL_SIZE-1:0] wr_j_i,
    input  logic [DATA_SIZE-1:0]    wr_data_i,
    input  logic                    rd_en_i,
    input  logic [CONTROL_SIZE-1:0] rd_i_i,
    input  logic [CONTROL_SIZE-1:0] rd_j_i,
    output logic [DATA_SIZE-1:0]    rd_data_o
);

    localparam int DEPTH = 2 ** (2 * CONTROL_SIZE);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] rd_data_q;

    // Storage sits outside the reset domain so a restarted stream sees the old contents.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{wr_i_i, wr_j_i}] <= wr_data_i;
        end
    end

    // Same-edge write to the read address returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= DATA_SIZE'(DATA_ZERO);
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[{rd_i_i, rd_j_i}];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/model_matrix_stream_transmitter.sv
// Streams a loaded matrix of up to 2**CONTROL_SIZE x 2**CONTROL_SIZE elements
// in row-major order, one element per consumer acknowledge.
module model_matrix_stream_transmitter
    import model_math_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input logic                              CLK,
    input logic                              RST,
    model_matrix_stream_transmitter_if.slave bus
);

    localparam logic [DATA_SIZE-1:0] ONE_D   = DATA_SIZE'(DATA_ONE);
    localparam logic [DATA_SIZE-1:0] ZERO_D  = DATA_SIZE'(DATA_ZERO);
    localparam logic [DATA_SIZE-1:0] MAX_DIM = ONE_D << CONTROL_SIZE;

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] i_q, i_d, j_q, j_d;
    logic [DATA_SIZE-1:0]    size_i_q, size_i_d, size_j_q, size_j_d;
    logic                    err_q, err_d;
    logic                    ready_q, ready_d;
    logic                    error_q, error_d;
    logic                    i_en_q, i_en_d;
    logic                    j_en_q, j_en_d;
    logic                    rd_en;
    logic                    size_bad;
    logic                    last_i, last_j;

    assign size_bad = (bus.SIZE_I_IN == ZERO_D) || (bus.SIZE_J_IN == ZERO_D) ||
                      (bus.SIZE_I_IN > MAX_DIM) || (bus.SIZE_J_IN > MAX_DIM);

    // Compare at full width against size-1 so the indices never need to wrap.
    assign last_i = (DATA_SIZE'(i_q) == size_i_q - ONE_D);
    assign last_j = (DATA_SIZE'(j_q) == size_j_q - ONE_D);

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        size_i_d = size_i_q;
        size_j_d = size_j_q;
        err_d    = err_q;
        ready_d  = CTRL_ZERO;
        error_d  = CTRL_ZERO;
        i_en_d   = CTRL_ZERO;
        j_en_d   = CTRL_ZERO;
        rd_en    = CTRL_ZERO;
        case (state_q)
            ST_STARTER: begin
                if (bus.START) begin
                    size_i_d = bus.SIZE_I_IN;
                    size_j_d = bus.SIZE_J_IN;
                    i_d      = '0;
                    j_d      = '0;
                    if (size_bad) begin
                        err_d   = CTRL_ONE;
                        state_d = ST_ENDER;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                rd_en   = CTRL_ONE;
                j_en_d  = CTRL_ONE;
                i_en_d  = (j_q == '0);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.NEXT_IN) begin
                    if (!last_j) begin
                        j_d     = j_q + CONTROL_SIZE'(DATA_ONE);
                        state_d = ST_EMIT;
                    end else if (!last_i) begin
                        i_d     = i_q + CONTROL_SIZE'(DATA_ONE);
                        j_d     = '0;
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_ENDER;
                    end
                end
            end
            ST_ENDER: begin
                ready_d = CTRL_ONE;
                error_d = err_q;
                err_d   = CTRL_ZERO;
                state_d = ST_STARTER;
            end
            default: begin
                state_d = ST_STARTER;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_STARTER;
            i_q      <= '0;
            j_q      <= '0;
            size_i_q <= ZERO_D;
            size_j_q <= ZERO_D;
            err_q    <= CTRL_ZERO;
            ready_q  <= CTRL_ZERO;
            error_q  <= CTRL_ZERO;
            i_en_q   <= CTRL_ZERO;
            j_en_q   <= CTRL_ZERO;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            size_i_q <= size_i_d;
            size_j_q <= size_j_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            i_en_q   <= i_en_d;
            j_en_q   <= j_en_d;
        end
    end

    model_matrix_stream_buffer #(
        .DATA_SIZE   (DATA_SIZE),
        .CONTROL_SIZE(CONTROL_SIZE)
    ) u_buffer (
        .clk       (CLK),
        .rst       (RST),
        .wr_en_i   (bus.WRITE_ENABLE),
        .wr_i_i    (bus.WRITE_I),
        .wr_j_i    (bus.WRITE_J),
        .wr_data_i (bus.WRITE_DATA),
        .rd_en_i   (rd_en),
        .rd_i_i    (i_q),
        .rd_j_i    (j_q),
        .rd_data_o (bus.DATA_OUT)
    );

    assign bus.READY             = ready_q;
    assign bus.ERROR             = error_q;
    assign bus.DATA_OUT_I_ENABLE = i_en_q;
    assign bus.DATA_OUT_J_ENABLE = j_en_q;
    assign bus.DBG_STATE         = state_q;

endmodule

// File: tb/tb_model_matrix_stream_transmitter.sv
// Randomized scoreboard bench for the matrix stream transmitter; the bench acts
// as loader and consumer and predicts every strobe and READY from a matrix model.
module tb_model_matrix_stream_transmitter;

    localparam int DS    = 64;
    localparam int CS    = 4;
    localparam int DIM   = 16;
    localparam int W     = DS + 2;
    localparam int LIMIT = 40;

    logic CLK;
    logic RST;

    model_matrix_stream_transmitter_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

    model_matrix_stream_transmitter #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [DS-1:0] model_mem [DIM][DIM];
    logic [W-1:0]  exp_q [$];
    logic [DS-1:0] last_data;
    int            checks;
    int            errors;

    // Clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [DS-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [DS-1:0] got, input logic [DS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic score(input string name, input logic [W-1:0] got);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected got=%0h exp=none", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s got=%0h exp=%0h", name, got, exp);
            end
        end
    endtask

    // Scoreboard monitor: record = {is_ready, i_strobe_or_error, data}
    initial begin : monitor
        last_data = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                last_data = '0;
            end else begin
                if (bus.DATA_OUT_J_ENABLE) begin
                    score("element", {1'b0, bus.DATA_OUT_I_ENABLE, bus.DATA_OUT});
                    last_data = bus.DATA_OUT;
                end else begin
                    check("data_hold", bus.DATA_OUT, last_data);
                    check("i_strobe_alone", DS'(bus.DATA_OUT_I_ENABLE), '0);
                end
                if (bus.READY) begin
                    score("ready", {1'b1, bus.ERROR, {DS{1'b0}}});
                end else begin
                    check("error_alone", DS'(bus.ERROR), '0);
                end
            end
        end
    end

    // Driver tasks
    task automatic write_elem(input int r, input int c, input logic [DS-1:0] d);
        bus.WRITE_ENABLE = 1'b1;
        bus.WRITE_I      = CS'(r);
        bus.WRITE_J      = CS'(c);
        bus.WRITE_DATA   = d;
        @(posedge CLK); #1;
        bus.WRITE_ENABLE = 1'b0;
        model_mem[r][c]  = d;
    endtask

    task automatic push_expected(input logic [DS-1:0] si, input logic [DS-1:0] sj, output int n);
        n = 0;
        if (si == 0 || sj == 0 || si > DIM || sj > DIM) begin
            exp_q.push_back({2'b11, {DS{1'b0}}});
        end else begin
            for (int r = 0; r < int'(si); r++) begin
                for (int c = 0; c < int'(sj); c++) begin
                    exp_q.push_back({1'b0, (c == 0), model_mem[r][c]});
                    n++;
                end
            end
            exp_q.push_back({2'b10, {DS{1'b0}}});
        end
    endtask

    task automatic wait_event(input bit keep_next, output int cyc, output bit rdy);
        cyc = 0;
        do begin
            @(posedge CLK); #1;
            cyc++;
            if (cyc == 1) begin
                bus.START = 1'b0;
                if (!keep_next) bus.NEXT_IN = 1'b0;
            end
        end while (!bus.DATA_OUT_J_ENABLE && !bus.READY && cyc < LIMIT);
        rdy = bus.READY;
    endtask

    task automatic run_stream(input logic [DS-1:0] si, input logic [DS-1:0] sj,
                              input int dmin, input int dmax, input bit poke);
        int n, cyc, d;
        bit rdy;
        push_expected(si, sj, n);
        bus.SIZE_I_IN = si;
        bus.SIZE_J_IN = sj;
        bus.START     = 1'b1;
        wait_event(1'b0, cyc, rdy);
        check("start_latency", DS'(cyc), 2);
        check("start_response", DS'(rdy), DS'(n == 0));
        for (int k = 1; k <= n; k++) begin
            d = $urandom_range(dmax, dmin);
            repeat (d) begin
                @(posedge CLK); #1;
                if (poke) begin
                    bus.START     = 1'($urandom_range(1, 0));
                    bus.SIZE_I_IN = DS'($urandom_range(20, 0));
                end
            end
            bus.START   = 1'b0;
            bus.NEXT_IN = 1'b1;
            wait_event(1'b0, cyc, rdy);
            check("next_latency", DS'(cyc), 2);
            check("ready_at_end", DS'(rdy), DS'(k == n));
        end
        repeat (3) @(posedge CLK);
        #1;
        check("queue_drained", DS'(exp_q.size()), 0);
    endtask

    task automatic hold_stream(input logic [DS-1:0] si, input logic [DS-1:0] sj);
        int n, cyc;
        push_expected(si, sj, n);
        bus.SIZE_I_IN = si;
        bus.SIZE_J_IN = sj;
        bus.NEXT_IN   = 1'b1;
        bus.START     = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        cyc = 0;
        while (!bus.READY && cyc < 4 * n + 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("hold_ready", DS'(bus.READY), 1);
        check("hold_cycles", DS'(cyc), DS'(2 * n + 1));
        bus.NEXT_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("hold_drained", DS'(exp_q.size()), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, DS'(bus.READY), 0);
        check({tag, "_error"}, DS'(bus.ERROR), 0);
        check({tag, "_i_en"}, DS'(bus.DATA_OUT_I_ENABLE), 0);
        check({tag, "_j_en"}, DS'(bus.DATA_OUT_J_ENABLE), 0);
        check({tag, "_data"}, bus.DATA_OUT, 0);
    endtask

    initial begin : stimulus
        int n, cyc;
        bit rdy;
        logic [DS-1:0] newv;
        checks           = 0;
        errors           = 0;
        RST              = 1'b1;
        bus.WRITE_ENABLE = 1'b0;
        bus.WRITE_I      = '0;
        bus.WRITE_J      = '0;
        bus.WRITE_DATA   = '0;
        bus.START        = 1'b0;
        bus.SIZE_I_IN    = '0;
        bus.SIZE_J_IN    = '0;
        bus.NEXT_IN      = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        RST = 1'b0;

        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                write_elem(r, c, rnd64());

        // 2x3 loaded with 10..15, acknowledge one cycle after each strobe
        for (int k = 0; k < 6; k++) write_elem(k / 3, k % 3, DS'(10 + k));
        run_stream(2, 3, 0, 0, 1'b0);

        // rejected sizes
        run_stream(0, 3, 0, 0, 1'b0);
        run_stream(3, 17, 0, 0, 1'b0);
        run_stream(17, 0, 0, 0, 1'b0);
        run_stream(64'h1_0000_0001, 2, 0, 0, 1'b0);

        // 1x1 holding 0xAB
        write_elem(0, 0, 64'hAB);
        run_stream(1, 1, 0, 0, 1'b0);

        // slow consumer with START pulsed while waiting
        run_stream(3, 4, 5, 5, 1'b1);

        // read-before-write on the address read in the emit cycle
        newv = rnd64();
        push_expected(1, 1, n);
        bus.SIZE_I_IN = 1;
        bus.SIZE_J_IN = 1;
        bus.START     = 1'b1;
        @(posedge CLK); #1;
        bus.START        = 1'b0;
        bus.WRITE_ENABLE = 1'b1;
        bus.WRITE_I      = '0;
        bus.WRITE_J      = '0;
        bus.WRITE_DATA   = newv;
        @(posedge CLK); #1;
        bus.WRITE_ENABLE = 1'b0;
        model_mem[0][0]  = newv;
        check("rbw_strobe", DS'(bus.DATA_OUT_J_ENABLE), 1);
        bus.NEXT_IN = 1'b1;
        wait_event(1'b0, cyc, rdy);
        check("rbw_ready", DS'(rdy), 1);
        run_stream(1, 1, 0, 1, 1'b0);

        // reset after the 3rd element of a 4x4 stream
        push_expected(4, 4, n);
        bus.SIZE_I_IN = 4;
        bus.SIZE_J_IN = 4;
        bus.START     = 1'b1;
        wait_event(1'b0, cyc, rdy);
        for (int k = 0; k < 2; k++) begin
            bus.NEXT_IN = 1'b1;
            wait_event(1'b0, cyc, rdy);
        end
        #6;
        RST = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("no_ready_after_reset", DS'(exp_q.size()), 0);
        run_stream(4, 4, 0, 2, 1'b0);

        // consumer acknowledging continuously
        hold_stream(3, 3);
        hold_stream(1, 1);

        // full-range boundaries
        run_stream(16, 16, 0, 0, 1'b0);
        run_stream(1, 16, 0, 1, 1'b0);
        run_stream(16, 1, 0, 1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            repeat (8) write_elem($urandom_range(15, 0), $urandom_range(15, 0), rnd64());
            if (t % 4 == 3)
                run_stream(DS'($urandom_range(40, 17)), DS'($urandom_range(16, 1)), 0, 0, 1'b0);
            run_stream(DS'($urandom_range(16, 1)), DS'($urandom_range(16, 1)), 0, 3, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
